// File: rtl/unireg_pkg.sv
// Shared definitions for the universal shift register.
// Provides the 2-bit mode type and its four encodings (74x194 style).
package unireg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam int MODE_W = 2;

endpackage

// File: rtl/unireg_cell.sv
// One bit of the universal shift register: 4:1 mode mux into a D flop.
// Ports: cp_i clock, cr_n_i async clear (loads RST_BIT), ce_i enable,
//   s_i mode, shr_i/shl_i neighbour or serial bits, d_i load bit,
//   q_o stored bit, qn_o its complement.
module unireg_cell
    import unireg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic  cp_i,
    input  logic  cr_n_i,
    input  logic  ce_i,
    input  mode_t s_i,
    input  logic  shr_i,
    input  logic  shl_i,
    input  logic  d_i,
    output logic  q_o,
    output logic  qn_o
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        if (ce_i) begin
            unique case (s_i)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = shr_i;
                MODE_SHL:  q_d = shl_i;
                MODE_LOAD: q_d = d_i;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge cp_i or negedge cr_n_i) begin
        if (!cr_n_i) begin
            q_q <= RST_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    // Complement is derived from the same flop so q/qn never agree.
    assign q_o  = q_q;
    assign qn_o = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Ports: cp clock, cr_n async active-low clear, ce enable, s mode,
//   dsr/dsl serial inputs, d load data, q contents, qn complement.
// Option: define UNIREG_RING_EN to add the ring port (rotate mode).
module univ_shift_reg
    import unireg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             cp,
    input  logic             cr_n,
    input  logic             ce,
    input  logic [1:0]       s,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
`ifdef UNIREG_RING_EN
    input  logic             ring,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    mode_t mode;
    logic  sr_in;
    logic  sl_in;

    assign mode = mode_t'(s);

`ifdef UNIREG_RING_EN
    // Ring feeds the far end back in, turning shifts into rotates.
    assign sr_in = ring ? q[WIDTH-1] : dsr;
    assign sl_in = ring ? q[0]       : dsl;
`else
    assign sr_in = dsr;
    assign sl_in = dsl;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shr_b;
        logic shl_b;

        if (i == 0) begin : g_lo
            assign shr_b = sr_in;
        end else begin : g_lo
            assign shr_b = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi
            assign shl_b = sl_in;
        end else begin : g_hi
            assign shl_b = q[i+1];
        end

        unireg_cell #(
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .cp_i   (cp),
            .cr_n_i (cr_n),
            .ce_i   (ce),
            .s_i    (mode),
            .shr_i  (shr_b),
            .shl_i  (shl_b),
            .d_i    (d[i]),
            .q_o    (q[i]),
            .qn_o   (qn[i])
        );
    end

endmodule
